vga_rx_monitor: RTL

- Receive side of the 640x480@60 VGA timing link: samples hsync/vsync/RGB on the pixel clock and recovers the pixel position.
- Checks every line and frame against the nominal timing and declares lock after consecutive good frames.
- While locked, emits a pixel stream (x, y, rgb, valid) for capture and compare logic.
- Sits on the loopback path for self-checking the VGA output, or on an external capture input.

---
 rtl/vga_timing_pkg.sv | 18 +
 rtl/vga_sync_edge.sv | 43 ++++
 rtl/vga_rx_monitor.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and the monitor FSM state type
//   no ports; imported by vga_rx_monitor
package vga_timing_pkg;
   localparam int H_SYNC      = 96;
   localparam int H_BACK      = 48;
   localparam int H_ACTIVE    = 640;
   localparam int H_TOTAL     = 800;
   localparam int V_SYNC      = 2;
   localparam int V_BACK      = 33;
   localparam int V_ACTIVE    = 480;
   localparam int V_TOTAL     = 525;
   localparam int LOCK_FRAMES = 2;
   localparam int H_START     = H_SYNC + H_BACK;
   localparam int H_END       = H_START + H_ACTIVE - 1;
   localparam int V_START     = V_SYNC + V_BACK;
   localparam int V_END       = V_START + V_ACTIVE - 1;
   typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers the VGA pins once and detects sync edges
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   hsync, vsync active-low syncs from the pins
//   rgb          {r,g,b} from the pins
//   hs1, vs1     registered syncs (stage s1)
//   rgb1         registered colour (stage s1)
//   ls, fs       line start (hsync fall), frame start (line start with vsync fall)
//   hrise, vfall hsync rise, vsync fall (any alignment)
module vga_sync_edge (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [11:0] rgb,
   output logic        hs1,
   output logic        vs1,
   output logic [11:0] rgb1,
   output logic        ls,
   output logic        fs,
   output logic        hrise,
   output logic        vfall
);
   logic hs2, vs2;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs1  <= 1'b0;
         vs1  <= 1'b0;
         rgb1 <= '0;
         hs2  <= 1'b0;
         vs2  <= 1'b0;
      end else begin
         hs1  <= hsync;
         vs1  <= vsync;
         rgb1 <= rgb;
         hs2  <= hs1;
         vs2  <= vs1;
      end
   end
   assign ls    = hs2 & ~hs1;
   assign fs    = ls & vs2 & ~vs1;
   assign hrise = hs1 & ~hs2;
   assign vfall = vs2 & ~vs1;
endmodule

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: recovers pixel position from a VGA link, checks line/frame timing and streams pixels once locked
//   clk, rst_n       pixel clock, asynchronous active-low reset
//   hsync, vsync     active-low syncs
//   vga_r/g/b        4-bit colour components
//   err_clr          single-cycle clear of err
//   pix_valid/x/y/rgb active pixel stream, 2 clocks after the pins, zero when not valid
//   frame_start      one-cycle pulse 2 clocks after the vsync pin falls
//   locked           timing lock status
//   err              sticky: timing mismatch seen while locked
module vga_rx_monitor #(
   parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int H_BACK      = vga_timing_pkg::H_BACK,
   parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
   parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
   parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int V_BACK      = vga_timing_pkg::V_BACK,
   parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
   parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
   parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [3:0]  vga_r,
   input  logic [3:0]  vga_g,
   input  logic [3:0]  vga_b,
   input  logic        err_clr,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [11:0] pix_rgb,
   output logic        frame_start,
   output logic        locked,
   output logic        err
);
   import vga_timing_pkg::*;
   localparam logic [9:0] HS  = 10'(H_SYNC);
   localparam logic [9:0] HT  = 10'(H_TOTAL);
   localparam logic [9:0] HT1 = 10'(H_TOTAL - 1);
   localparam logic [9:0] H0  = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] H1  = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
   localparam logic [9:0] VS  = 10'(V_SYNC);
   localparam logic [9:0] VT  = 10'(V_TOTAL);
   localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);
   localparam logic [9:0] V0  = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] V1  = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
   localparam logic [2:0] LF  = 3'(LOCK_FRAMES);
   logic        hs1, vs1, ls, fs, hrise, vfall;
   logic [11:0] rgb1;
   logic [9:0]  hcnt_q, vcnt_q, hcnt, vcnt;
   logic        mism, pv, bad, frame_bad;
   logic [2:0]  good_cnt;
   state_t      state;

   vga_sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .hsync (hsync),
      .vsync (vsync),
      .rgb   ({vga_r, vga_g, vga_b}),
      .hs1   (hs1),
      .vs1   (vs1),
      .rgb1  (rgb1),
      .ls    (ls),
      .fs    (fs),
      .hrise (hrise),
      .vfall (vfall)
   );

   // hcnt/vcnt are the position of the s1 sample; the _q copies hold the previous one.
   // Both saturate at their total so a missing sync is reported once, then again at the late sync.
   always_comb begin
      hcnt = ls ? '0 : hcnt_q == HT ? hcnt_q : hcnt_q + 10'd1;
      vcnt = fs ? '0 : (!ls || vcnt_q == VT) ? vcnt_q : vcnt_q + 10'd1;
      mism = (hrise != (hcnt == HS)) || (ls != (hcnt_q == HT1)) || (fs && vcnt_q != VT1) ||
             (vfall && !ls) || (ls && vs1 != (vcnt >= VS && vcnt < VT));
      pv   = state == LOCKED && hcnt >= H0 && hcnt <= H1 && vcnt >= V0 && vcnt <= V1;
      bad  = frame_bad || mism;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         state       <= SEARCH;
         good_cnt    <= '0;
         frame_bad   <= 1'b0;
         locked      <= 1'b0;
         err         <= 1'b0;
         frame_start <= 1'b0;
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_rgb     <= '0;
      end else begin
         hcnt_q      <= hcnt;
         vcnt_q      <= vcnt;
         frame_start <= fs;
         pix_valid   <= pv;
         pix_x       <= pv ? hcnt - H0 : '0;
         pix_y       <= pv ? vcnt - V0 : '0;
         pix_rgb     <= pv ? rgb1 : '0;
         err         <= (err && !err_clr) || (state == LOCKED && mism);
         case (state)
            SEARCH: begin
               good_cnt  <= '0;
               frame_bad <= 1'b0;
               if (fs) state <= CHECK;
            end
            CHECK: begin
               frame_bad <= fs ? 1'b0 : bad;
               if (fs) begin
                  good_cnt <= bad ? '0 : good_cnt + 3'd1;
                  if (!bad && good_cnt + 3'd1 == LF) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (mism) begin
                  state    <= SEARCH;
                  locked   <= 1'b0;
                  good_cnt <= '0;
               end
            end
            default: state <= SEARCH;
         endcase
      end
   end
endmodule
